// File: rtl/conv_pkg.sv
// Shared constants and state encodings for the conv-layer data buffer.
package conv_pkg;
    localparam int IMG_W  = 28;
    localparam int IMG_H  = 28;
    localparam int WIN    = 5;
    localparam int ADDR_W = 5;

    typedef enum logic [1:0] {
        BANK_EMPTY   = 2'd0,
        BANK_FILLING = 2'd1,
        BANK_FULL    = 2'd2
    } bank_state_t;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_BUSY = 1'b1
    } rd_state_t;
endpackage

// File: rtl/data_buf_ctrl_if.sv
// Pixel-stream input, conv-engine column read port and start/done handshake.
interface data_buf_ctrl_if;
    import conv_pkg::*;

    logic              pix_in;
    logic              pix_in_vld;
    logic              pix_in_rdy;
    logic [ADDR_W-1:0] data_rd_addr;
    logic [ADDR_W-1:0] row_cnt;
    logic [WIN-1:0]    col_data;
    logic              cal_start;
    logic              cal_done;

    modport slave (
        input  pix_in, pix_in_vld, data_rd_addr, row_cnt, cal_done,
        output pix_in_rdy, col_data, cal_start
    );

    modport master (
        output pix_in, pix_in_vld, data_rd_addr, row_cnt, cal_done,
        input  pix_in_rdy, col_data, cal_start
    );
endinterface

// File: rtl/data_bank.sv
// One IMG_H x IMG_W binary image store: single-pixel write, combinational
// WIN-row column read with zero padding outside the image.
module data_bank
    import conv_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_row,
    input  logic [ADDR_W-1:0] wr_col,
    input  logic              wr_bit,
    input  logic [ADDR_W-1:0] rd_row,
    input  logic [ADDR_W-1:0] rd_col,
    output logic [WIN-1:0]    rd_data
);
    logic [IMG_W-1:0] mem [IMG_H];

    // Pixel write; contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_row][wr_col] <= wr_bit;
        end
    end

    // Rows past the bottom edge or columns past the right edge read as 0.
    for (genvar i = 0; i < WIN; i++) begin : g_rd
        logic [ADDR_W:0] row;
        assign row = {1'b0, rd_row} + (ADDR_W + 1)'(i);
        assign rd_data[i] = (row < (ADDR_W + 1)'(IMG_H) && rd_col < ADDR_W'(IMG_W))
                          ? mem[row[ADDR_W-1:0]][rd_col] : 1'b0;
    end
endmodule

// File: rtl/data_buf_ctrl.sv
// Image buffer and column-read responder for the conv engine.
// Build option: DATA_BUF_PINGPONG_EN selects two banks (load next image while
// the current one is convolved); undefined gives a single bank.
module data_buf_ctrl
    import conv_pkg::*;
(
    input  logic           sclk,
    input  logic           s_rst_n,
    data_buf_ctrl_if.slave bus
);
    logic [ADDR_W-1:0] wr_col;
    logic [ADDR_W-1:0] wr_row;
    bank_state_t       bank_st [2];
    rd_state_t         rd_state;
    rd_state_t         rd_next;
    logic              wr_bank;
    logic              rd_bank;
    logic              accept;
    logic              last_pix;
    logic              release_bank;
    logic              start_next;
    logic [WIN-1:0]    rd_data0;
    logic [WIN-1:0]    rd_sel;

    assign bus.pix_in_rdy = s_rst_n && (bank_st[wr_bank] != BANK_FULL);
    assign accept   = bus.pix_in_vld && bus.pix_in_rdy;
    assign last_pix = accept && (wr_col == ADDR_W'(IMG_W - 1))
                             && (wr_row == ADDR_W'(IMG_H - 1));

    // Raster write position: column wraps into the next row, clears after the last pixel.
    always_ff @(posedge sclk) begin
        if (!s_rst_n) begin
            wr_col <= '0;
            wr_row <= '0;
        end else if (accept) begin
            if (wr_col == ADDR_W'(IMG_W - 1)) begin
                wr_col <= '0;
                wr_row <= (wr_row == ADDR_W'(IMG_H - 1)) ? '0 : wr_row + 1'b1;
            end else begin
                wr_col <= wr_col + 1'b1;
            end
        end
    end

    // Bank lifecycle: loading marks FILLING/FULL, release by the reader empties it.
    always_ff @(posedge sclk) begin
        if (!s_rst_n) begin
            bank_st[0] <= BANK_EMPTY;
            bank_st[1] <= BANK_EMPTY;
        end else begin
            for (int b = 0; b < 2; b++) begin
                if (release_bank && rd_bank == 1'(b)) begin
                    bank_st[b] <= BANK_EMPTY;
                end else if (accept && wr_bank == 1'(b)) begin
                    bank_st[b] <= last_pix ? BANK_FULL : BANK_FILLING;
                end
            end
        end
    end

    data_bank u_bank0 (
        .clk     (sclk),
        .we      (accept && !wr_bank),
        .wr_row  (wr_row),
        .wr_col  (wr_col),
        .wr_bit  (bus.pix_in),
        .rd_row  (bus.row_cnt),
        .rd_col  (bus.data_rd_addr),
        .rd_data (rd_data0)
    );

`ifdef DATA_BUF_PINGPONG_EN
    logic [WIN-1:0] rd_data1;

    // Writer moves on after a complete image; reader moves on after release.
    always_ff @(posedge sclk) begin
        if (!s_rst_n) begin
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
        end else begin
            if (last_pix)     wr_bank <= ~wr_bank;
            if (release_bank) rd_bank <= ~rd_bank;
        end
    end

    data_bank u_bank1 (
        .clk     (sclk),
        .we      (accept && wr_bank),
        .wr_row  (wr_row),
        .wr_col  (wr_col),
        .wr_bit  (bus.pix_in),
        .rd_row  (bus.row_cnt),
        .rd_col  (bus.data_rd_addr),
        .rd_data (rd_data1)
    );

    assign rd_sel = rd_bank ? rd_data1 : rd_data0;
`else
    assign wr_bank = 1'b0;
    assign rd_bank = 1'b0;
    assign rd_sel  = rd_data0;
`endif

    // Reader next state: start the engine on a full bank, release it on cal_done.
    always_comb begin
        rd_next      = rd_state;
        start_next   = 1'b0;
        release_bank = 1'b0;
        case (rd_state)
            RD_IDLE: begin
                if (bank_st[rd_bank] == BANK_FULL) begin
                    start_next = 1'b1;
                    rd_next    = RD_BUSY;
                end
            end
            RD_BUSY: begin
                if (bus.cal_done) begin
                    release_bank = 1'b1;
                    rd_next      = RD_IDLE;
                end
            end
            default: rd_next = RD_IDLE;
        endcase
    end

    // Reader state, cal_start pulse and one-cycle-latency column data.
    always_ff @(posedge sclk) begin
        if (!s_rst_n) begin
            rd_state      <= RD_IDLE;
            bus.cal_start <= 1'b0;
            bus.col_data  <= '0;
        end else begin
            rd_state      <= rd_next;
            bus.cal_start <= start_next;
            bus.col_data  <= rd_sel;
        end
    end
endmodule
